// File: rtl/dma_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_line_arbiter
// Purpose  : Shares the single-cacheline DMA read/write channels between two
//            requesters (0 = CPU memory controller, 1 = host preload/debug
//            engine). Accepts one line-sized load or store at a time, runs the
//            DMA go/addr/size/enable handshake for a 1-line transfer, and
//            returns the loaded line plus a completion pulse to the owner.
//            Ties are broken round-robin against the last completed owner.
// Ports    :
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req_valid/we [1:0]      per-requester request valid / store select
//   i_req_addr  [2*AW]        requester i at [i*AW +: AW]
//   i_req_wdata [2*DW]        requester i at [i*DW +: DW]
//   o_req_ready/done/rvalid   per-requester accept / completion / load-valid
//   o_rsp_rdata               last loaded line
//   o_busy, o_xfer_count      activity flag, completed transaction count
//   o_dma_*                   DMA channel controls (addr, size, go, en, data)
//   i_dma_*                   DMA status and read line
// Revision : 1.0 - initial release
// ============================================================================
module dma_line_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int SIZE_WIDTH = 43
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [1:0]              i_req_valid,
    input  logic [1:0]              i_req_we,
    input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
    output logic [1:0]              o_req_ready,
    output logic [1:0]              o_req_done,
    output logic [1:0]              o_req_rvalid,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_busy,
    output logic [31:0]             o_xfer_count,
    output logic [ADDR_WIDTH-1:0]   o_dma_rd_addr,
    output logic [ADDR_WIDTH-1:0]   o_dma_wr_addr,
    output logic [SIZE_WIDTH-1:0]   o_dma_rd_size,
    output logic [SIZE_WIDTH-1:0]   o_dma_wr_size,
    output logic                    o_dma_rd_go,
    output logic                    o_dma_wr_go,
    output logic                    o_dma_rd_en,
    output logic                    o_dma_wr_en,
    output logic [DATA_WIDTH-1:0]   o_dma_wr_data,
    input  logic                    i_dma_empty,
    input  logic                    i_dma_full,
    input  logic                    i_dma_rd_done,
    input  logic                    i_dma_wr_done,
    input  logic [DATA_WIDTH-1:0]   i_dma_rd_data
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_GO      = 3'd1;
    localparam logic [2:0] c_S_RD_POP  = 3'd2;
    localparam logic [2:0] c_S_RD_WAIT = 3'd3;
    localparam logic [2:0] c_S_WR_PUSH = 3'd4;
    localparam logic [2:0] c_S_WR_WAIT = 3'd5;
    localparam logic [2:0] c_S_RESP    = 3'd6;

    localparam logic [SIZE_WIDTH-1:0] c_SIZE_ONE = {{(SIZE_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic                  r_last_grant;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [31:0]           r_xfer_count;
    logic [1:0]            r_req_ready;
    logic [1:0]            r_req_done;
    logic [1:0]            r_req_rvalid;
    logic                  r_busy;
    logic                  r_rd_go;
    logic                  r_wr_go;
    logic                  r_rd_en;
    logic                  r_wr_en;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [2:0]            w_state_nxt;
    logic                  w_req_any;
    logic                  w_win;
    logic                  w_win_we;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_wdata;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_complete;
    logic [1:0]            w_ready_nxt;
    logic [1:0]            w_done_nxt;
    logic [1:0]            w_rvalid_nxt;
    logic                  w_busy_nxt;
    logic                  w_rd_go_nxt;
    logic                  w_wr_go_nxt;
    logic                  w_rd_en_nxt;
    logic                  w_wr_en_nxt;

    // Arbitration: a lone requester always wins; on a tie the requester
    // that did not complete last wins.
    assign w_req_any   = |i_req_valid;
    assign w_win       = (&i_req_valid) ? ~r_last_grant : i_req_valid[1];
    assign w_win_we    = w_win ? i_req_we[1] : i_req_we[0];
    assign w_win_addr  = w_win ? i_req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                               : i_req_addr[0 +: ADDR_WIDTH];
    assign w_win_wdata = w_win ? i_req_wdata[DATA_WIDTH +: DATA_WIDTH]
                               : i_req_wdata[0 +: DATA_WIDTH];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. The DMA done inputs are only looked at in the
    // WAIT states, so a done level left over from the previous transfer
    // cannot end the new one early.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:    if (w_req_any)      w_state_nxt = c_S_GO;
            c_S_GO:      w_state_nxt = r_we ? c_S_WR_PUSH : c_S_RD_POP;
            c_S_RD_POP:  if (!i_dma_empty)   w_state_nxt = c_S_RD_WAIT;
            c_S_RD_WAIT: if (i_dma_rd_done)  w_state_nxt = c_S_RESP;
            c_S_WR_PUSH: if (!i_dma_full)    w_state_nxt = c_S_WR_WAIT;
            c_S_WR_WAIT: if (i_dma_wr_done)  w_state_nxt = c_S_RESP;
            c_S_RESP:    w_state_nxt = c_S_IDLE;
            default:     w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode. Produces the next value of every registered
    // output, so each pulse appears the cycle after its state decides it.
    // ------------------------------------------------------------------
    always_comb begin
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        w_ready_nxt  = 2'b00;
        w_done_nxt   = 2'b00;
        w_rvalid_nxt = 2'b00;
        w_rd_go_nxt  = 1'b0;
        w_wr_go_nxt  = 1'b0;
        w_rd_en_nxt  = 1'b0;
        w_wr_en_nxt  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_req_any) begin
                    w_accept           = 1'b1;
                    w_ready_nxt[w_win] = 1'b1;
                end
            end
            c_S_GO: begin
                w_rd_go_nxt = ~r_we;
                w_wr_go_nxt = r_we;
            end
            c_S_RD_POP: begin
                if (!i_dma_empty) begin
                    w_rd_en_nxt = 1'b1;
                    w_capture   = 1'b1;
                end
            end
            c_S_WR_PUSH: begin
                if (!i_dma_full) begin
                    w_wr_en_nxt = 1'b1;
                end
            end
            c_S_RESP: begin
                w_complete            = 1'b1;
                w_done_nxt[r_owner]   = 1'b1;
                w_rvalid_nxt[r_owner] = ~r_we;
            end
            default: begin
                w_accept = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != c_S_IDLE);
    end

    // ------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_xfer_count <= 32'd0;
            r_req_ready  <= 2'b00;
            r_req_done   <= 2'b00;
            r_req_rvalid <= 2'b00;
            r_busy       <= 1'b0;
            r_rd_go      <= 1'b0;
            r_wr_go      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
        end else begin
            r_req_ready  <= w_ready_nxt;
            r_req_done   <= w_done_nxt;
            r_req_rvalid <= w_rvalid_nxt;
            r_busy       <= w_busy_nxt;
            r_rd_go      <= w_rd_go_nxt;
            r_wr_go      <= w_wr_go_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_wr_en      <= w_wr_en_nxt;
            // Transaction fields are latched once at accept and held through
            // IDLE so the DMA sees stable address/data for the whole transfer.
            if (w_accept) begin
                r_owner <= w_win;
                r_we    <= w_win_we;
                r_addr  <= w_win_addr;
                r_wdata <= w_win_wdata;
            end
            if (w_capture) begin
                r_rdata <= i_dma_rd_data;
            end
            if (w_complete) begin
                r_last_grant <= r_owner;
                r_xfer_count <= r_xfer_count + 32'd1;
            end
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_req_done    = r_req_done;
    assign o_req_rvalid  = r_req_rvalid;
    assign o_rsp_rdata   = r_rdata;
    assign o_busy        = r_busy;
    assign o_xfer_count  = r_xfer_count;
    assign o_dma_rd_addr = r_addr;
    assign o_dma_wr_addr = r_addr;
    assign o_dma_rd_size = c_SIZE_ONE;
    assign o_dma_wr_size = c_SIZE_ONE;
    assign o_dma_rd_go   = r_rd_go;
    assign o_dma_wr_go   = r_wr_go;
    assign o_dma_rd_en   = r_rd_en;
    assign o_dma_wr_en   = r_wr_en;
    assign o_dma_wr_data = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dma_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_line_arbiter
// Purpose  : Directed self-checking bench for dma_line_arbiter. Completions
//            are checked against a queue of expected responses filled when
//            each request is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_line_arbiter;

    logic           clk;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_we;
    logic [127:0]   req_addr;
    logic [1023:0]  req_wdata;
    logic [1:0]     req_ready;
    logic [1:0]     req_done;
    logic [1:0]     req_rvalid;
    logic [511:0]   rsp_rdata;
    logic           busy;
    logic [31:0]    xfer_count;
    logic [63:0]    dma_rd_addr;
    logic [63:0]    dma_wr_addr;
    logic [42:0]    dma_rd_size;
    logic [42:0]    dma_wr_size;
    logic           dma_rd_go;
    logic           dma_wr_go;
    logic           dma_rd_en;
    logic           dma_wr_en;
    logic [511:0]   dma_wr_data;
    logic           dma_empty;
    logic           dma_full;
    logic           dma_rd_done;
    logic           dma_wr_done;
    logic [511:0]   dma_rd_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0]   done;
        logic [1:0]   rvalid;
        logic [511:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    dma_line_arbiter #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (512),
        .SIZE_WIDTH (43)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .i_req_we      (req_we),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_req_ready   (req_ready),
        .o_req_done    (req_done),
        .o_req_rvalid  (req_rvalid),
        .o_rsp_rdata   (rsp_rdata),
        .o_busy        (busy),
        .o_xfer_count  (xfer_count),
        .o_dma_rd_addr (dma_rd_addr),
        .o_dma_wr_addr (dma_wr_addr),
        .o_dma_rd_size (dma_rd_size),
        .o_dma_wr_size (dma_wr_size),
        .o_dma_rd_go   (dma_rd_go),
        .o_dma_wr_go   (dma_wr_go),
        .o_dma_rd_en   (dma_rd_en),
        .o_dma_wr_en   (dma_wr_en),
        .o_dma_wr_data (dma_wr_data),
        .i_dma_empty   (dma_empty),
        .i_dma_full    (dma_full),
        .i_dma_rd_done (dma_rd_done),
        .i_dma_wr_done (dma_wr_done),
        .i_dma_rd_data (dma_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (req_ready != 2'b00) break;
        end
        chk("ready_seen", 64'(req_ready != 2'b00), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (req_done != 2'b00) break;
        end
        chk("done_seen", 64'(req_done != 2'b00), 64'd1);
    endtask

    task automatic push_exp(input logic [1:0] d, input logic [1:0] rv, input logic [511:0] rd);
        exp_t e;
        e.done   = d;
        e.rvalid = rv;
        e.rdata  = rd;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every completion pulse must match the oldest expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (req_done != 2'b00) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra_done", 64'(req_done), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_done", 64'(req_done), 64'(e.done));
                chk("sb_rvalid", 64'(req_rvalid), 64'(e.rvalid));
                chkd("sb_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    logic [511:0] line_ab;
    logic [511:0] line_cd;
    logic [511:0] line_55;
    logic [511:0] line_99;
    logic [511:0] line_k;
    logic [511:0] last_rdata;
    int           prev_acc;
    logic         rr_owner;

    initial begin
        line_ab = {64{8'hAB}};
        line_cd = {64{8'hCD}};
        line_55 = {64{8'h55}};
        line_99 = {64{8'h99}};
        rst_n       = 1'b0;
        req_valid   = 2'b00;
        req_we      = 2'b00;
        req_addr    = '0;
        req_wdata   = '0;
        dma_empty   = 1'b1;
        dma_full    = 1'b1;
        dma_rd_done = 1'b0;
        dma_wr_done = 1'b0;
        dma_rd_data = '0;
        repeat (3) tick();

        // ---------------- reset state ----------------
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_done", 64'(req_done), 64'd0);
        chk("rst_xfer", 64'(xfer_count), 64'd0);
        chkd("rst_rdata", rsp_rdata, 512'd0);
        chk("rst_rd_addr", dma_rd_addr, 64'd0);
        chk("rst_rd_size", 64'(dma_rd_size), 64'd1);
        chk("rst_wr_size", 64'(dma_wr_size), 64'd1);
        chk("rst_go", 64'({dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}), 64'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- single load, port 0 ----------------
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr[63:0] = 64'h1000;
        tick();                                   // T
        chk("ld_ready", 64'(req_ready), 64'd1);
        chk("ld_busy", 64'(busy), 64'd1);
        req_valid   = 2'b00;
        dma_empty   = 1'b0;
        dma_rd_data = line_ab;
        push_exp(2'b01, 2'b01, line_ab);
        tick();                                   // T+1
        chk("ld_rd_go", 64'(dma_rd_go), 64'd1);
        chk("ld_wr_go", 64'(dma_wr_go), 64'd0);
        chk("ld_rd_addr", dma_rd_addr, 64'h1000);
        chk("ld_rd_size", 64'(dma_rd_size), 64'd1);
        chk("ld_rd_en_early", 64'(dma_rd_en), 64'd0);
        tick();                                   // T+2
        chk("ld_rd_en", 64'(dma_rd_en), 64'd1);
        dma_empty   = 1'b1;
        dma_rd_done = 1'b1;
        tick();                                   // T+3
        chk("ld_done_early", 64'(req_done), 64'd0);
        dma_rd_done = 1'b0;
        tick();                                   // T+4
        chk("ld_done_t4", 64'(req_done), 64'd1);
        chkd("ld_rdata", rsp_rdata, line_ab);
        chk("ld_xfer", 64'(xfer_count), 64'd1);
        chk("ld_busy_end", 64'(busy), 64'd0);
        last_rdata = line_ab;

        // ---------------- single store, port 1, full stall ----------------
        req_valid = 2'b10;
        req_we    = 2'b10;
        req_addr[127:64]   = 64'h2040;
        req_wdata[1023:512] = line_55;
        dma_full  = 1'b1;
        tick();                                   // T
        chk("st_ready", 64'(req_ready), 64'd2);
        chk("st_wr_addr", dma_wr_addr, 64'h2040);
        req_valid = 2'b00;
        push_exp(2'b10, 2'b00, last_rdata);
        tick();                                   // T+1
        chk("st_wr_go", 64'(dma_wr_go), 64'd1);
        chk("st_rd_go", 64'(dma_rd_go), 64'd0);
        chkd("st_wr_data", dma_wr_data, line_55);
        for (int i = 0; i < 3; i++) begin
            tick();                               // T+2..T+4
            chk("st_wr_en_stall", 64'(dma_wr_en), 64'd0);
        end
        dma_full = 1'b0;
        tick();                                   // T+5
        chk("st_wr_en", 64'(dma_wr_en), 64'd1);
        chkd("st_wr_data_push", dma_wr_data, line_55);
        dma_full    = 1'b1;
        dma_wr_done = 1'b1;
        tick();
        dma_wr_done = 1'b0;
        tick();
        chk("st_done", 64'(req_done), 64'd2);
        chk("st_rvalid", 64'(req_rvalid), 64'd0);
        chk("st_xfer", 64'(xfer_count), 64'd2);

        // ---------------- stale rd_done held across GO/RD_POP ----------------
        dma_rd_done = 1'b1;
        dma_empty   = 1'b1;
        req_valid   = 2'b01;
        req_we      = 2'b00;
        req_addr[63:0] = 64'h3000;
        tick();                                   // T
        chk("hd_ready", 64'(req_ready), 64'd1);
        req_valid   = 2'b00;
        dma_rd_data = line_cd;
        push_exp(2'b01, 2'b01, line_cd);
        tick();                                   // T+1
        chk("hd_rd_go", 64'(dma_rd_go), 64'd1);
        for (int i = 0; i < 2; i++) begin
            tick();                               // T+2, T+3
            chk("hd_no_rd_en", 64'(dma_rd_en), 64'd0);
            chk("hd_no_done", 64'(req_done), 64'd0);
        end
        dma_empty = 1'b0;
        tick();                                   // T+4
        chk("hd_rd_en", 64'(dma_rd_en), 64'd1);
        dma_empty = 1'b1;
        tick();                                   // T+5 (RESP)
        chk("hd_done_not_yet", 64'(req_done), 64'd0);
        tick();                                   // T+6
        chk("hd_done", 64'(req_done), 64'd1);
        dma_rd_done = 1'b0;
        last_rdata  = line_cd;

        // ---------------- reset during WR_WAIT ----------------
        dma_full  = 1'b0;
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr[63:0]    = 64'h4000;
        req_wdata[511:0]  = line_99;
        tick();                                   // T
        chk("rw_ready", 64'(req_ready), 64'd1);
        req_valid = 2'b00;
        tick();                                   // T+1 go
        tick();                                   // T+2 wr_en
        chk("rw_wr_en", 64'(dma_wr_en), 64'd1);
        dma_full = 1'b1;
        tick();                                   // T+3, in WR_WAIT
        rst_n = 1'b0;
        tick();
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_done", 64'(req_done), 64'd0);
        chk("rw_xfer", 64'(xfer_count), 64'd0);
        chkd("rw_rdata", rsp_rdata, 512'd0);
        chk("rw_wr_addr", dma_wr_addr, 64'd0);
        chkd("rw_wr_data", dma_wr_data, 512'd0);
        chk("rw_pulses", 64'({dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}), 64'd0);
        rst_n       = 1'b1;
        dma_wr_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_no_done_after", 64'(req_done), 64'd0);
        end
        dma_wr_done = 1'b0;
        last_rdata  = '0;

        // ---------------- round-robin, both ports valid ----------------
        dma_empty   = 1'b0;
        dma_full    = 1'b0;
        dma_rd_done = 1'b1;
        dma_wr_done = 1'b1;
        req_we      = 2'b10;
        req_addr    = {64'h6000, 64'h5000};
        req_wdata   = {line_55, line_99};
        req_valid   = 2'b11;
        rr_owner    = 1'b0;
        prev_acc    = 0;
        for (int k = 0; k < 6; k++) begin
            wait_ready(12);
            chk("rr_grant", 64'(req_ready), rr_owner ? 64'd2 : 64'd1);
            chk("rr_addr", dma_rd_addr, rr_owner ? 64'h6000 : 64'h5000);
            if (k > 0) chk("rr_spacing", 64'(cyc - prev_acc), 64'd5);
            prev_acc = cyc;
            line_k = {64{8'(8'h10 + k)}};
            dma_rd_data = line_k;
            if (rr_owner) begin
                push_exp(2'b10, 2'b00, last_rdata);
            end else begin
                push_exp(2'b01, 2'b01, line_k);
                last_rdata = line_k;
            end
            if (k == 5) req_valid = 2'b00;
            rr_owner = ~rr_owner;
        end
        wait_done(12);
        chk("rr_xfer", 64'(xfer_count), 64'd6);
        dma_rd_done = 1'b0;
        dma_wr_done = 1'b0;
        tick();
        chk("rr_idle", 64'(busy), 64'd0);

        // ---------------- xfer_count wrap ----------------
        force dut.r_xfer_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_xfer_count;
        chk("wrap_preload", 64'(xfer_count), 64'hFFFF_FFFF);
        dma_rd_done = 1'b1;
        dma_rd_data = line_ab;
        req_we      = 2'b00;
        req_addr[127:64] = 64'h7000;
        req_valid   = 2'b10;
        wait_ready(4);
        chk("wrap_ready", 64'(req_ready), 64'd2);
        req_valid = 2'b00;
        push_exp(2'b10, 2'b10, line_ab);
        wait_done(12);
        chk("wrap_xfer", 64'(xfer_count), 64'd0);
        dma_rd_done = 1'b0;
        dma_empty   = 1'b1;
        dma_full    = 1'b1;
        repeat (2) tick();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dma_line_arbiter.md
# dma_line_arbiter

Sequencer and round-robin arbiter that shares the single-cacheline DMA read/write channels between two requesters: port 0 is the CPU memory controller, port 1 is the host preload/debug engine. It accepts one line-sized load or store at a time and drives the DMA go/addr/size/enable handshake for a 1-line transfer. It returns the read line and a completion pulse to the owning requester. It sits inside the AFU between the requesters and the `dma_if` peripheral port, and replaces direct mem_ctrl-to-DMA wiring.

## Interface
- ADDR_WIDTH, 64: virtual byte address width.
- DATA_WIDTH, 512: cacheline width.
- SIZE_WIDTH, 43: DMA size field width (cacheline address width + 1).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  2  bit i: requester i has a request; held with its fields until req_ready[i].
- req_we  in  2  bit i: 1 = store line, 0 = load line.
- req_addr  in  2*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2*DATA_WIDTH  store data, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  2  one-cycle accept pulse to the granted requester.
- req_done  out  2  one-cycle completion pulse to the owning requester.
- req_rvalid  out  2  with req_done, set only for loads.
- rsp_rdata  out  DATA_WIDTH  last loaded line; held until the next load completes.
- busy  out  1  high in every state except IDLE.
- xfer_count  out  32  completed transactions since reset; wraps.
- dma_rd_addr / dma_wr_addr  out  ADDR_WIDTH  both driven from the latched address.
- dma_rd_size / dma_wr_size  out  SIZE_WIDTH  constant 1.
- dma_rd_go / dma_wr_go  out  1  one-cycle start pulses.
- dma_rd_en / dma_wr_en  out  1  one-cycle pop/push pulses.
- dma_wr_data  out  DATA_WIDTH  latched store data.
- dma_empty, dma_full, dma_rd_done, dma_wr_done  in  1  DMA status.
- dma_rd_data  in  DATA_WIDTH  DMA read line.

## Operation
- States: IDLE, GO, RD_POP, RD_WAIT, WR_PUSH, WR_WAIT, RESP.
- IDLE: the arbiter evaluates req_valid.
  - If exactly one bit is set, that requester wins.
  - If both are set, the winner is the requester other than `last_grant`.
  - On a win: latch we, addr, wdata and owner id; pulse req_ready[owner]; go to GO.
  - If no bit is set, stay in IDLE.
- GO: pulse dma_rd_go (load) or dma_wr_go (store). Next state is RD_POP for a load, WR_PUSH for a store.
- RD_POP: when dma_empty == 0, pulse dma_rd_en and capture dma_rd_data into rsp_rdata; go to RD_WAIT.
- RD_WAIT: wait for dma_rd_done == 1, then go to RESP.
- WR_PUSH: when dma_full == 0, pulse dma_wr_en; dma_wr_data holds the latched line; go to WR_WAIT.
- WR_WAIT: wait for dma_wr_done == 1, then go to RESP.
- RESP:
  - Pulse req_done[owner].
  - Pulse req_rvalid[owner] if the transaction was a load.
  - Set last_grant = owner.
  - Increment xfer_count (modulo 2^32).
  - Return to IDLE.
- dma_*_done inputs are ignored outside RD_WAIT/WR_WAIT. This masks a done level still held from the previous transfer, which the DMA clears after the new go.
- Address, size and wr_data outputs are stable from GO through WR_WAIT/RD_WAIT. In IDLE they hold their last value.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All pulses, busy, req_ready, req_done and req_rvalid = 0.
  - rsp_rdata = 0, xfer_count = 0; addr/data outputs = 0.
  - dma_rd_size/dma_wr_size = 1.
- Accept at cycle T means req_ready is high in T. The go pulse follows in T+1.
- Minimum load latency: rd_en at T+2, done pulse at T+4 (rd_done seen at T+3). Minimum store latency is the same.
- Back-to-back: the next accept can happen in the cycle after RESP, giving a 5-cycle minimum per transaction.
- Stalls: any number of cycles in RD_POP (empty), WR_PUSH (full) or the WAIT states. There is no timeout.
- A req_valid dropped before its ready is never granted. Requesters must not change fields while valid is high.
- Reset mid-transaction: the FSM returns to IDLE at the next edge and no done pulse is issued for the aborted transaction. The DMA is restarted by the next go.

## Test plan
- Single load, port 0, addr 0x1000, DMA returns 0xAB… line with empty low at T+2 and rd_done at T+3 -> ready at T, rd_go at T+1 with rd_addr 0x1000 and size 1, rd_en at T+2, req_done[0] and req_rvalid[0] at T+4, rsp_rdata = 0xAB…, xfer_count = 1.
- Single store, port 1, addr 0x2040, wdata 0x55…, full high for 3 cycles -> wr_en delayed exactly 3 cycles, wr_data 0x55…, req_done[1] with req_rvalid = 0.
- Both ports valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; xfer_count = 6.
- dma_rd_done held high from the previous transfer during GO/RD_POP -> no early RESP; RESP occurs only after rd_en and rd_done in RD_WAIT.
- rst_n low for 1 cycle during WR_WAIT -> no req_done; all outputs return to reset values; a following request completes normally.
- xfer_count preloaded via 2^32 transactions (force to 0xFFFFFFFF), then one load -> xfer_count = 0.
